// File: rtl/serial_sub8.sv
// Bit-serial subtractor: Diff = A - B - Bin (mod 2^WIDTH), one bit per clock, LSB first.
// Optional feature macro: SERIAL_SUB8_OVF_EN adds the registered two's-complement overflow output Ovf.
module serial_sub8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
`ifdef SERIAL_SUB8_OVF_EN
  output logic             Ovf,
`endif
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_SUB8_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d;
  logic             w_br_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  // One-bit full-subtractor slice on the current LSBs of the operand shift registers
  assign w_a_bit   = r_a[0];
  assign w_b_bit   = r_b[0];
  assign w_d       = w_a_bit ^ w_b_bit ^ r_br;
  assign w_br_nxt  = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_res_nxt = (r_res >> 1) | {w_d, {(WIDTH-1){1'b0}}};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status flags registered from the next state so they line up with r_state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
    end
  end

  // Operand capture, serial shift and result commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
`ifdef SERIAL_SUB8_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_br  <= Bin;
            r_cnt <= '0;
            r_res <= '0;
`ifdef SERIAL_SUB8_OVF_EN
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
`endif
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_nxt;
          r_res <= w_res_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= w_res_nxt;
            r_bout <= w_br_nxt;
`ifdef SERIAL_SUB8_OVF_EN
            // w_d is the MSB of the final difference
            r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign Diff = r_diff;
  assign Bout = r_bout;
  assign busy = r_busy;
  assign done = r_done;
`ifdef SERIAL_SUB8_OVF_EN
  assign Ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub8.sv
// Directed bench for serial_sub8 (WIDTH=8) with hand-computed expected results.
module tb_serial_sub8;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB8_OVF_EN
  logic         Ovf;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] prev_d;

  serial_sub8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Diff  (Diff),
    .Bout  (Bout),
    .busy  (busy),
`ifdef SERIAL_SUB8_OVF_EN
    .Ovf   (Ovf),
`endif
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Full operation from IDLE; operands are scrambled right after acceptance
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W-1:0] exp_d, input logic exp_bo,
                        input logic exp_ovf);
    logic bad;
    A = a; B = b; Bin = bin; start = 1'b1;
    tick();
    start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    bad = 1'b0;
    for (int k = 1; k < int'(W); k++) begin
      tick();
      if (done !== 1'b0 || Diff !== prev_d || busy !== 1'b1) bad = 1'b1;
    end
    check({tag, "_hold_during_run"}, 32'(bad), 32'd0);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_diff"}, 32'(Diff), 32'(exp_d));
    check({tag, "_bout"}, 32'(Bout), 32'(exp_bo));
`ifdef SERIAL_SUB8_OVF_EN
    check({tag, "_ovf"}, 32'(Ovf), 32'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    prev_d = exp_d;
    tick();
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    prev_d = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_diff", 32'(Diff), 32'h0);
    check("rst_bout", 32'(Bout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    run_op("op05m03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("op03m05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("op00m00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("op80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("op05m03b", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    // Start during RUN must be ignored
    A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 3; k++) begin tick(); ndone += int'(done); end
    A = 8'hFF; B = 8'h00; start = 1'b1;
    tick(); ndone += int'(done);
    start = 1'b0;
    for (int k = 5; k <= int'(W) - 1; k++) begin tick(); ndone += int'(done); end
    tick();
    check("ign_done", 32'(done), 32'd1);
    check("ign_diff", 32'(Diff), 32'h0F);
    check("ign_bout", 32'(Bout), 32'd0);
    for (int k = 0; k < 12; k++) begin tick(); ndone += int'(done); end
    check("ign_single_done", 32'(ndone), 32'd0);
    prev_d = 8'h0F;

    // Reset in the middle of RUN aborts the operation
    A = 8'h77; B = 8'h11; Bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(Diff), 32'h0);
    check("abort_bout", 32'(Bout), 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin tick(); ndone += int'(done); end
    check("abort_no_done", 32'(ndone), 32'd0);
    prev_d = 8'h00;
    run_op("op09m04", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    // Start held high: back-to-back operations, next accept at W+2 edges
    A = 8'h20; B = 8'h10; Bin = 1'b0; start = 1'b1;
    tick();
    A = 8'h30;
    for (int k = 1; k <= int'(W); k++) tick();
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_diff1", 32'(Diff), 32'h10);
    tick();
    check("b2b_idle_gap", 32'(busy), 32'd0);
    tick();
    check("b2b_accept2", 32'(busy), 32'd1);
    start = 1'b0;
    for (int k = 1; k <= int'(W); k++) tick();
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_diff2", 32'(Diff), 32'h20);
    check("b2b_bout2", 32'(Bout), 32'd0);
    tick();
    check("b2b_end", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
